// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for the execute stage.
// Divides operand magnitudes over 32 cycles, applies sign correction and
// holds the quotient or remainder until the execute stage retires the
// instruction, drops the request, or flushes.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [2*XLEN+2:0]   es_to_div_bus,
   output logic [XLEN:0]       div_to_es_bus,
   input  logic                flush,
   input  logic                req_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   logic [5:0]        cnt;
   logic [XLEN:0]     rem;        // partial remainder; the top bit stays clear
   logic [XLEN-1:0]   quo;        // dividend magnitude shifting out, quotient shifting in
   logic [XLEN-1:0]   div_abs;    // divisor magnitude
   logic              use_mod_r;
   logic              q_neg;
   logic              r_neg;
   logic [XLEN-1:0]   result;

   // request bus fields
   logic              req_valid;
   logic              use_mod;
   logic              is_unsigned;
   logic [XLEN-1:0]   src1;
   logic [XLEN-1:0]   src2;

   assign req_valid   = es_to_div_bus[2*XLEN+2];
   assign use_mod     = es_to_div_bus[2*XLEN+1];
   assign is_unsigned = es_to_div_bus[2*XLEN];
   assign src1        = es_to_div_bus[2*XLEN-1:XLEN];
   assign src2        = es_to_div_bus[XLEN-1:0];

   // operand magnitudes and sign of the final results
   logic              src1_neg;
   logic              src2_neg;
   logic [XLEN-1:0]   src1_abs;
   logic [XLEN-1:0]   src2_abs;

   assign src1_neg = !is_unsigned && src1[XLEN-1];
   assign src2_neg = !is_unsigned && src2[XLEN-1];
   assign src1_abs = src1_neg ? (~src1 + 1'b1) : src1;
   assign src2_abs = src2_neg ? (~src2 + 1'b1) : src2;

   // one restoring step: shift {rem,quo} left, try subtracting the divisor
   logic [XLEN+1:0]   trial;
   logic              trial_ok;
   logic [XLEN:0]     rem_next;
   logic [XLEN-1:0]   quo_next;
   logic [XLEN-1:0]   q_final;
   logic [XLEN-1:0]   r_final;

   // datapath for the current iteration and the sign-corrected results
   always_comb begin
      // NOTE: every always_comb output gets a value on every path so no latch is inferred.
      trial    = {rem, quo[XLEN-1]} - {2'b00, div_abs};
      trial_ok = !trial[XLEN+1];
      rem_next = trial_ok ? trial[XLEN:0] : {rem[XLEN-1:0], quo[XLEN-1]};
      quo_next = {quo[XLEN-2:0], trial_ok};
      q_final  = q_neg ? (~quo_next + 1'b1) : quo_next;
      r_final  = r_neg ? (~rem_next[XLEN-1:0] + 1'b1) : rem_next[XLEN-1:0];
   end

   // control FSM and datapath registers; flush outranks everything but reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rem       <= '0;
         quo       <= '0;
         div_abs   <= '0;
         use_mod_r <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         result    <= '0;
      end else if (flush) begin
         state  <= S_IDLE;
         result <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  use_mod_r <= use_mod;
                  q_neg     <= src1_neg ^ src2_neg;
                  r_neg     <= src1_neg;
                  div_abs   <= src2_abs;
                  quo       <= src1_abs;
                  rem       <= '0;
                  cnt       <= '0;
                  if (src2 == '0) begin
                     result <= use_mod ? src1 : '1;
                     state  <= S_DONE;
                  end else begin
                     state  <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               if (!req_valid) begin
                  state <= S_IDLE;
               end else begin
                  rem <= rem_next;
                  quo <= quo_next;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(XLEN - 1)) begin
                     result <= use_mod_r ? r_final : q_final;
                     state  <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (req_done || !req_valid) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign div_to_es_bus = {result, (state == S_DONE)};

endmodule
